// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle sequencing controller. Steps each instruction
//             through fetch, decode, execute, memory and write-back states
//             and drives the datapath control set. It stalls on mem_ready
//             and halts on an undefined opcode.
//  Ports    : clk, reset (sync, active-high)
//             opcode[5:0], zero, mem_ready           - inputs
//             pcWrite, irWrite, memRead, memWrite,
//             regWrite, regDst, memToReg, link,
//             ALUsrcA, ALUsrcB[1:0], ALUop[2:0],
//             pcSource[1:0], byteOperations          - datapath controls
//             instrDone, illegal, state[3:0]         - status / debug
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       link,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUop,
    output logic [1:0] pcSource,
    output logic       byteOperations,
    output logic       instrDone,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b000010;
    localparam logic [5:0] c_OP_SUBI  = 6'b000011;
    localparam logic [5:0] c_OP_ANDI  = 6'b000100;
    localparam logic [5:0] c_OP_ORI   = 6'b000101;
    localparam logic [5:0] c_OP_SLTI  = 6'b000111;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_LB    = 6'b001001;
    localparam logic [5:0] c_OP_SW    = 6'b010000;
    localparam logic [5:0] c_OP_SB    = 6'b010001;
    localparam logic [5:0] c_OP_BEQ   = 6'b100011;
    localparam logic [5:0] c_OP_BNE   = 6'b100111;
    localparam logic [5:0] c_OP_J     = 6'b111000;
    localparam logic [5:0] c_OP_JAL   = 6'b111001;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    state_t     r_state;
    logic       r_illegal;

    logic       w_is_rtype;
    logic       w_is_alui;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_byte;
    logic       w_is_branch;
    logic       w_is_jump;
    logic [2:0] w_imm_aluop;

    // Opcode class decode, used from DECODE onward.
    assign w_is_rtype  = (opcode == c_OP_RTYPE);
    assign w_is_alui   = (opcode == c_OP_ADDI) || (opcode == c_OP_SUBI) ||
                         (opcode == c_OP_ANDI) || (opcode == c_OP_ORI)  ||
                         (opcode == c_OP_SLTI);
    assign w_is_load   = (opcode == c_OP_LW) || (opcode == c_OP_LB);
    assign w_is_store  = (opcode == c_OP_SW) || (opcode == c_OP_SB);
    assign w_is_byte   = (opcode == c_OP_LB) || (opcode == c_OP_SB);
    assign w_is_branch = (opcode == c_OP_BEQ) || (opcode == c_OP_BNE);
    assign w_is_jump   = (opcode == c_OP_J) || (opcode == c_OP_JAL);

    always_comb begin
        w_imm_aluop = 3'b000;
        case (opcode)
            c_OP_SUBI: w_imm_aluop = 3'b001;
            c_OP_ANDI: w_imm_aluop = 3'b010;
            c_OP_ORI:  w_imm_aluop = 3'b011;
            c_OP_SLTI: w_imm_aluop = 3'b100;
            default:   w_imm_aluop = 3'b000;
        endcase
    end

    // State sequencing. The illegal flag is set on the same edge that enters
    // HALT, and only reset leaves HALT, so the flag stays sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:   if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_load || w_is_store) r_state <= S_MEMADDR;
                    else if (w_is_rtype)         r_state <= S_RTEXEC;
                    else if (w_is_alui)          r_state <= S_IEXEC;
                    else if (w_is_branch)        r_state <= S_BRANCH;
                    else if (w_is_jump)          r_state <= S_JUMP;
                    else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_MEMADDR: r_state <= w_is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
                S_RTEXEC:  r_state <= S_RTWB;
                S_RTWB:    r_state <= S_FETCH;
                S_IEXEC:   r_state <= S_IWB;
                S_IWB:     r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from the state register. Several strobes must follow
    // mem_ready / zero within the same cycle, so this decode is combinational;
    // reset only forces everything to zero so no write escapes in that cycle.
    always_comb begin
        pcWrite        = 1'b0;
        irWrite        = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        regWrite       = 1'b0;
        regDst         = 1'b0;
        memToReg       = 1'b0;
        link           = 1'b0;
        ALUsrcA        = 1'b0;
        ALUsrcB        = 2'b00;
        ALUop          = 3'b000;
        pcSource       = 2'b00;
        byteOperations = 1'b0;
        instrDone      = 1'b0;
        illegal        = 1'b0;
        state          = 4'd0;
        if (!reset) begin
            state   = r_state;
            illegal = r_illegal;
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    ALUsrcB = 2'b01;
                    irWrite = mem_ready;
                    pcWrite = mem_ready;
                end
                S_DECODE: ALUsrcB = 2'b11;   // branch target precompute
                S_MEMADDR: begin
                    ALUsrcA        = 1'b1;
                    ALUsrcB        = 2'b10;
                    byteOperations = w_is_byte;
                end
                S_MEMRD: begin
                    memRead        = 1'b1;
                    byteOperations = w_is_byte;
                end
                S_MEMWB: begin
                    regWrite       = 1'b1;
                    memToReg       = 1'b1;
                    byteOperations = w_is_byte;
                    instrDone      = 1'b1;
                end
                S_MEMWR: begin
                    memWrite       = 1'b1;
                    byteOperations = w_is_byte;
                    instrDone      = mem_ready;
                end
                S_RTEXEC: begin
                    ALUsrcA = 1'b1;
                    ALUop   = 3'b111;
                end
                S_RTWB: begin
                    regWrite  = 1'b1;
                    regDst    = 1'b1;
                    ALUop     = 3'b111;
                    instrDone = 1'b1;
                end
                S_IEXEC: begin
                    ALUsrcA = 1'b1;
                    ALUsrcB = 2'b10;
                    ALUop   = w_imm_aluop;
                end
                S_IWB: begin
                    regWrite  = 1'b1;
                    instrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUsrcA   = 1'b1;
                    ALUop     = 3'b001;
                    pcSource  = 2'b01;
                    instrDone = 1'b1;
                    pcWrite   = (opcode == c_OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pcSource  = 2'b10;
                    pcWrite   = 1'b1;
                    instrDone = 1'b1;
                    regWrite  = (opcode == c_OP_JAL);
                    link      = (opcode == c_OP_JAL);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control. Each test task walks
//             a table of (reset, mem_ready, zero, expected state) per cycle,
//             pushes the expected output vector on a scoreboard queue and
//             compares it against the DUT on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcWrite, irWrite, memRead, memWrite, regWrite, regDst;
    logic       memToReg, link, ALUsrcA, byteOperations, instrDone, illegal;
    logic [1:0] ALUsrcB, pcSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    multicycle_control dut (
        .clk            (clk),
        .reset          (reset),
        .opcode         (opcode),
        .zero           (zero),
        .mem_ready      (mem_ready),
        .pcWrite        (pcWrite),
        .irWrite        (irWrite),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .regWrite       (regWrite),
        .regDst         (regDst),
        .memToReg       (memToReg),
        .link           (link),
        .ALUsrcA        (ALUsrcA),
        .ALUsrcB        (ALUsrcB),
        .ALUop          (ALUop),
        .pcSource       (pcSource),
        .byteOperations (byteOperations),
        .instrDone      (instrDone),
        .illegal        (illegal),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] obs;
    assign obs = {state, pcWrite, irWrite, memRead, memWrite, regWrite, regDst,
                  memToReg, link, ALUsrcA, ALUsrcB, ALUop, pcSource,
                  byteOperations, instrDone, illegal};

    logic [22:0] sb[$];
    logic [22:0] exp_v;
    int          n_total = 0;
    int          n_bad   = 0;

    // Reference output table written from the state descriptions.
    function automatic logic [22:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr, input logic z);
        logic pw, iw, mrd, mwr, rw, rd, m2r, lk, sa, by, dn, il;
        logic [1:0] sbm, ps;
        logic [2:0] ao;
        logic       isb;
        {pw, iw, mrd, mwr, rw, rd, m2r, lk, sa, by, dn, il} = '0;
        sbm = 2'b00; ps = 2'b00; ao = 3'b000;
        isb = (op == 6'b001001) || (op == 6'b010001);
        case (st)
            4'd0:  begin mrd = 1'b1; sbm = 2'b01; iw = mr; pw = mr; end
            4'd1:  sbm = 2'b11;
            4'd2:  begin sa = 1'b1; sbm = 2'b10; by = isb; end
            4'd3:  begin mrd = 1'b1; by = isb; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; by = isb; dn = 1'b1; end
            4'd5:  begin mwr = 1'b1; by = isb; dn = mr; end
            4'd6:  begin sa = 1'b1; ao = 3'b111; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; ao = 3'b111; dn = 1'b1; end
            4'd8:  begin
                sa = 1'b1; sbm = 2'b10;
                case (op)
                    6'b000011: ao = 3'b001;
                    6'b000100: ao = 3'b010;
                    6'b000101: ao = 3'b011;
                    6'b000111: ao = 3'b100;
                    default:   ao = 3'b000;
                endcase
            end
            4'd9:  begin rw = 1'b1; dn = 1'b1; end
            4'd10: begin
                sa = 1'b1; ao = 3'b001; ps = 2'b01; dn = 1'b1;
                pw = (op == 6'b100111) ? !z : z;
            end
            4'd11: begin
                ps = 2'b10; pw = 1'b1; dn = 1'b1;
                rw = (op == 6'b111001); lk = (op == 6'b111001);
            end
            4'd12: il = 1'b1;
            default: ;
        endcase
        return {st, pw, iw, mrd, mwr, rw, rd, m2r, lk, sa, sbm, ao, ps, by, dn, il};
    endfunction

    // Drives one cycle of inputs and queues the expected outputs for it.
    task automatic drive(input logic rst, input logic mr, input logic z,
                         input logic [5:0] op, input logic [3:0] st);
        reset = rst; mem_ready = mr; zero = z; opcode = op;
        sb.push_back(rst ? 23'd0 : model(st, op, mr, z));
    endtask

    task automatic test_reset();
        bit rs[4] = '{1, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(rs[i], 1'b1, 1'b0, 6'b000000, 4'd0);
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        int st[4] = '{0, 1, 6, 7};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 6'b000000, 4'(st[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rtype cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        logic [5:0] ops[5] = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000111};
        int st[4] = '{0, 1, 8, 9};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b0, 1'b1, 1'b0, ops[k], 4'(st[i]));
                @(negedge clk);
                exp_v = sb.pop_front(); n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL itype op=%b cyc%0d got=%h want=%h", ops[k], i, obs, exp_v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load();
        // lw with no stall, then lb stalled two cycles in MEMRD
        logic [5:0] op[12] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000,
                               6'b001001, 6'b001001, 6'b001001, 6'b001001, 6'b001001,
                               6'b001001, 6'b001001};
        int st[12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 3, 3, 4};
        bit mr[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, mr[i], 1'b0, op[i], 4'(st[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL load cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        // sb with a FETCH stall and a MEMWR stall, then sw unstalled
        logic [5:0] op[10] = '{6'b010001, 6'b010001, 6'b010001, 6'b010001, 6'b010001,
                               6'b010001, 6'b010000, 6'b010000, 6'b010000, 6'b010000};
        int st[10] = '{0, 0, 1, 2, 5, 5, 0, 1, 2, 5};
        bit mr[10] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, mr[i], 1'b0, op[i], 4'(st[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL store cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[4] = '{6'b100011, 6'b100011, 6'b100111, 6'b100111};
        bit zs[4] = '{1, 0, 1, 0};
        int st[3] = '{0, 1, 10};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 1'b1, zs[k], ops[k], 4'(st[i]));
                @(negedge clk);
                exp_v = sb.pop_front(); n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL branch op=%b z=%0d cyc%0d got=%h want=%h",
                             ops[k], zs[k], i, obs, exp_v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jump();
        logic [5:0] ops[2] = '{6'b111001, 6'b111000};
        int st[3] = '{0, 1, 11};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 1'b1, 1'b0, ops[k], 4'(st[i]));
                @(negedge clk);
                exp_v = sb.pop_front(); n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL jump op=%b cyc%0d got=%h want=%h", ops[k], i, obs, exp_v);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_midop();
        // lw reset while stalled in MEMRD; sw reset in MEMWR with mem_ready high
        logic [5:0] op[9] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000,
                              6'b010000, 6'b010000, 6'b010000, 6'b010000};
        int st[9] = '{0, 1, 2, 3, 0, 0, 1, 2, 0};
        bit rs[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        bit mr[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            drive(rs[i], mr[i], 1'b0, op[i], 4'(st[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midop_reset cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        // FETCH, DECODE, 10 cycles of HALT, reset, then FETCH again
        for (int i = 0; i < 14; i++) begin
            if (i < 12)
                drive(1'b0, i < 2 ? 1'b1 : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 6'b111111,
                      i == 0 ? 4'd0 : (i == 1 ? 4'd1 : 4'd12));
            else if (i == 12)
                drive(1'b1, 1'b1, 1'b0, 6'b111111, 4'd0);
            else
                drive(1'b0, 1'b1, 1'b0, 6'b111111, 4'd0);
            @(negedge clk);
            exp_v = sb.pop_front(); n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL illegal cyc%0d got=%h want=%h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_reset_midop();
        test_illegal();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the processor datapath: it replaces the single-cycle decode with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back cycles. It drives the same control-signal set the datapath already uses (regDst, memRead, memWrite, ALUop, ALUsrc, regWrite, byteOperations) plus multi-cycle strobes. It also stalls on a memory ready handshake and halts on illegal opcodes.

## Interface
- No parameters; opcode width fixed at 6, state width fixed at 4.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction-register opcode field; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pcWrite  out  1  load PC.
- irWrite  out  1  load instruction register.
- memRead, memWrite  out  1 each  memory strobes, held until mem_ready.
- regWrite, regDst  out  1 each  register-file write enable; rd (1) or rt (0) destination.
- memToReg, link  out  1 each  write-back from memory data; write PC+4 to $31 (jal).
- ALUsrcA  out  1  0 = PC, 1 = register A.
- ALUsrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- ALUop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 111 use funct.
- pcSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- byteOperations  out  1  byte access (lb/sb).
- instrDone  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  sticky; set on an undefined opcode.
- state  out  4  current state, for debug.

## Operation
- Opcodes: R-type 000000, addi 000010, subi 000011, andi 000100, ori 000101, slti 000111, lw 001000, lb 001001, sw 010000, sb 010001, beq 100011, bne 100111, j 111000, jal 111001. Any other opcode is illegal.
- States: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, HALT=12.
- FETCH:
  - Outputs: memRead=1, ALUsrcA=0, ALUsrcB=01, ALUop=000, pcSource=00, irWrite=pcWrite=mem_ready.
  - Transition: to DECODE when mem_ready=1, else stay.
- DECODE:
  - Outputs: ALUsrcA=0, ALUsrcB=11, ALUop=000 (branch target precompute).
  - Transitions: lw/lb/sw/sb→MEMADDR; R-type→RTEXEC; addi/subi/andi/ori/slti→IEXEC; beq/bne→BRANCH; j/jal→JUMP; illegal→HALT.
- MEMADDR:
  - Outputs: ALUsrcA=1, ALUsrcB=10, ALUop=000, byteOperations=(lb|sb).
  - Transitions: loads→MEMRD, stores→MEMWR.
- MEMRD:
  - Outputs: memRead=1, byteOperations per opcode.
  - Transition: to MEMWB on mem_ready, else stay.
- MEMWB:
  - Outputs: regWrite=1, regDst=0, memToReg=1, byteOperations per opcode, instrDone=1.
  - Transition: to FETCH.
- MEMWR:
  - Outputs: memWrite=1, byteOperations per opcode; instrDone=mem_ready.
  - Transition: to FETCH on mem_ready, else stay.
- RTEXEC:
  - Outputs: ALUsrcA=1, ALUsrcB=00, ALUop=111.
  - Transition: to RTWB.
- RTWB:
  - Outputs: regWrite=1, regDst=1, ALUop=111, instrDone=1.
  - Transition: to FETCH.
- IEXEC:
  - Outputs: ALUsrcA=1, ALUsrcB=10; ALUop: addi 000, subi 001, andi 010, ori 011, slti 100.
  - Transition: to IWB.
- IWB:
  - Outputs: regWrite=1, regDst=0, instrDone=1.
  - Transition: to FETCH.
- BRANCH:
  - Outputs: ALUsrcA=1, ALUsrcB=00, ALUop=001, pcSource=01, instrDone=1.
  - pcWrite = zero for beq, ~zero for bne.
  - Transition: to FETCH.
- JUMP:
  - Outputs: pcSource=10, pcWrite=1, instrDone=1.
  - jal additionally sets regWrite=1 and link=1.
  - Transition: to FETCH.
- HALT:
  - Outputs: illegal=1; all strobes 0.
  - Transition: stays in HALT until reset.
- Defaults: every output not listed for a state is 0.

## Timing
- Reset (synchronous): next edge forces state=FETCH and illegal=0. While reset is high, all outputs are 0; FETCH outputs resume in the cycle after reset is released.
- Reset mid-operation (any state, including a mem_ready stall): aborts the instruction; no pcWrite, regWrite or memWrite is asserted in the reset cycle.
- Outputs depend on state, plus opcode (decoded in DECODE and later), plus mem_ready/zero only where listed. No output depends combinationally on reset except the forcing to 0.
- Latency with mem_ready tied high, in cycles FETCH-to-retire inclusive:
  - R-type and I-type ALU: 4.
  - lw/lb: 5.
  - sw/sb: 4.
  - beq/bne and j/jal: 3.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay asserted and the access is not re-issued.
- instrDone pulses exactly once per instruction, in its final cycle.

## Test plan
- Reset: hold reset 2 cycles with mem_ready=1 → all outputs 0 during reset; then state=0, memRead=1, irWrite=1, pcWrite=1 in the first cycle after release.
- R-type (opcode 000000), mem_ready=1 → state sequence 0,1,6,7,0; RTWB shows regWrite=1, regDst=1, ALUop=111, instrDone=1.
- lb (001001) with mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; byteOperations=1 in states 2–4; memToReg=1 in MEMWB.
- Branches:
  - beq (100011) with zero=1 → pcWrite=1, pcSource=01 in state 10.
  - bne (100111) with zero=1 → pcWrite=0.
  - bne with zero=0 → pcWrite=1.
- jal (111001) → state 11 shows pcWrite=1, pcSource=10, regWrite=1, link=1. j (111000) → the same but regWrite=0, link=0.
- Illegal opcode 111111 → DECODE→HALT; illegal=1 stays set and all strobes stay 0 for 10 cycles; reset returns state to 0 and clears illegal.
